// File: rtl/debug_scratch_ram_pkg.sv
// debug_scratch_ram_pkg: shared state type, sizing constants and clog2 helper
package debug_scratch_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   localparam int DEBUG_DATA_RAM_LOG       = 8;
   localparam int DEBUG_DATA_RAM_WIDTH_LOG = 6;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/debug_scratch_ptr.sv
// debug_scratch_ptr: byte pointer for the scratch port with load override and post-increment
module debug_scratch_ptr #(
   parameter int PW = 11
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en_i,
   input  logic          ld_i,
   input  logic [PW-1:0] ld_val_i,
   input  logic          op_i,
   input  logic          inc_i,
   output logic [PW-1:0] addr_o
);

   logic [PW-1:0] ptr_q, ptr_d;

   assign addr_o = ld_i ? ld_val_i : ptr_q;

   // a load takes effect this cycle; an executed op with auto-increment steps past the used address
   always_comb begin
      ptr_d = ptr_q;
      if (en_i) ptr_d = (op_i && inc_i) ? addr_o + PW'(1) : addr_o;
   end

   // pointer register
   always_ff @(posedge clk or negedge reset)
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;

endmodule

// File: rtl/debug_scratch_ram.sv
// debug_scratch_ram: cleared-on-reset RAM with core word ports and a byte-wide debug scratch port
module debug_scratch_ram
   import debug_scratch_ram_pkg::*;
#(
   parameter  int DEPTH    = 256,
   parameter  int INDEX    = DEBUG_DATA_RAM_LOG,
   parameter  int WIDTH    = 64,
   parameter  int NUM_RD   = 2,
   localparam int BYTES    = WIDTH / 8,
   localparam int BYTE_LOG = clog2(BYTES)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_RD*INDEX-1:0]   rdAddr_i,
   output logic [NUM_RD*WIDTH-1:0]   rdData_o,
   input  logic [INDEX-1:0]          wrAddr_i,
   input  logic [WIDTH-1:0]          wrData_i,
   input  logic [BYTES-1:0]          wrByteEn_i,
   input  logic                      we_i,
   output logic                      wrReady_o,
   input  logic [INDEX+BYTE_LOG-1:0] scratchAddr_i,
   input  logic                      scratchAddrLd_i,
   input  logic                      scratchAutoInc_i,
   input  logic [7:0]                scratchWrData_i,
   input  logic                      scratchWrEn_i,
   input  logic                      scratchRdEn_i,
   output logic [7:0]                scratchRdData_o,
   output logic                      scratchRdValid_o,
   output logic                      initDone_o
);

   localparam int PW = INDEX + BYTE_LOG;

   logic [WIDTH-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [INDEX-1:0]  idx_q, idx_d;
   logic              pend_vld_q, pend_vld_d;
   logic [INDEX-1:0]  pend_addr_q, pend_addr_d;
   logic [WIDTH-1:0]  pend_data_q, pend_data_d;
   logic [BYTES-1:0]  pend_be_q, pend_be_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rd_vld_q, rd_vld_d;

   logic              idle, core_acc, scr_rd;
   logic [PW-1:0]     scr_addr;
   logic [INDEX-1:0]  scr_entry;
   logic [BYTE_LOG-1:0] scr_lane;
   logic [WIDTH-1:0]  scr_word;
   logic [7:0]        scr_byte;

   logic              mem_we;
   logic [INDEX-1:0]  mem_addr;
   logic [WIDTH-1:0]  mem_data;
   logic [BYTES-1:0]  mem_be;

   assign idle             = state_q == IDLE;
   assign initDone_o       = idle;
   assign wrReady_o        = idle && !pend_vld_q;
   assign core_acc         = we_i && wrReady_o;
   assign scr_rd           = idle && scratchRdEn_i && !scratchWrEn_i;
   assign scr_entry        = scr_addr[PW-1:BYTE_LOG];
   assign scr_lane         = scr_addr[BYTE_LOG-1:0];
   assign scr_word         = mem_q[scr_entry];
   assign scratchRdData_o  = rd_data_q;
   assign scratchRdValid_o = rd_vld_q;

   debug_scratch_ptr #(.PW(PW)) u_ptr (
      .clk      (clk),
      .reset    (reset),
      .en_i     (idle),
      .ld_i     (scratchAddrLd_i),
      .ld_val_i (scratchAddr_i),
      .op_i     (scratchWrEn_i || scratchRdEn_i),
      .inc_i    (scratchAutoInc_i),
      .addr_o   (scr_addr)
   );

   genvar r;
   generate
      for (r = 0; r < NUM_RD; r++) begin : g_rd
         assign rdData_o[r*WIDTH +: WIDTH] = idle ? mem_q[rdAddr_i[r*INDEX +: INDEX]] : '0;
      end
   endgenerate

   // pick the addressed byte lane out of the scratch-selected word
   always_comb begin
      scr_byte = '0;
      for (int b = 0; b < BYTES; b++)
         if (scr_lane == BYTE_LOG'(b)) scr_byte = scr_word[b*8 +: 8];
   end

   // single array write port: sweep, then scratch byte, then parked core write, then direct core write
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      pend_be_d   = pend_be_q;
      rd_vld_d    = scr_rd;
      rd_data_d   = scr_rd ? scr_byte : rd_data_q;
      mem_we      = 1'b0;
      mem_addr    = idx_q;
      mem_data    = '0;
      mem_be      = '1;
      if (!idle) begin
         mem_we  = 1'b1;
         idx_d   = idx_q + INDEX'(1);
         state_d = (idx_q == INDEX'(DEPTH - 1)) ? IDLE : CLEAR;
      end else if (scratchWrEn_i) begin
         mem_we   = 1'b1;
         mem_addr = scr_entry;
         mem_be   = BYTES'(1) << scr_lane;
         mem_data = {BYTES{scratchWrData_i}};
         if (core_acc) begin
            pend_vld_d  = 1'b1;
            pend_addr_d = wrAddr_i;
            pend_data_d = wrData_i;
            pend_be_d   = wrByteEn_i;
         end
      end else if (pend_vld_q) begin
         mem_we     = 1'b1;
         mem_addr   = pend_addr_q;
         mem_data   = pend_data_q;
         mem_be     = pend_be_q;
         pend_vld_d = 1'b0;
      end else if (core_acc) begin
         mem_we   = 1'b1;
         mem_addr = wrAddr_i;
         mem_data = wrData_i;
         mem_be   = wrByteEn_i;
      end
   end

   // control registers; the array itself carries no reset
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q     <= CLEAR;
         idx_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
         pend_be_q   <= '0;
         rd_data_q   <= '0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
         pend_be_q   <= pend_be_d;
         rd_data_q   <= rd_data_d;
         rd_vld_q    <= rd_vld_d;
      end

   // byte-lane masked array write
   always_ff @(posedge clk)
      if (mem_we)
         for (int b = 0; b < BYTES; b++)
            if (mem_be[b]) mem_q[mem_addr][b*8 +: 8] <= mem_data[b*8 +: 8];

endmodule

// File: tb/tb_debug_scratch_ram.sv
// tb_debug_scratch_ram: randomized and directed checks against an array/queue reference model
module tb_debug_scratch_ram;

   localparam int DEPTH = 256, INDEX = 8, WIDTH = 64, NUM_RD = 2, BYTES = 8, PW = 11;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic [NUM_RD*INDEX-1:0] rdAddr;
   logic [NUM_RD*WIDTH-1:0] rdData;
   logic [INDEX-1:0]        wrAddr;
   logic [WIDTH-1:0]        wrData;
   logic [BYTES-1:0]        wrByteEn;
   logic                    we, wrReady;
   logic [PW-1:0]           scratchAddr;
   logic                    scratchAddrLd, scratchAutoInc, scratchWrEn, scratchRdEn;
   logic [7:0]              scratchWrData, scratchRdData;
   logic                    scratchRdValid, initDone;

   debug_scratch_ram dut (
      .clk              (clk),
      .reset            (reset),
      .rdAddr_i         (rdAddr),
      .rdData_o         (rdData),
      .wrAddr_i         (wrAddr),
      .wrData_i         (wrData),
      .wrByteEn_i       (wrByteEn),
      .we_i             (we),
      .wrReady_o        (wrReady),
      .scratchAddr_i    (scratchAddr),
      .scratchAddrLd_i  (scratchAddrLd),
      .scratchAutoInc_i (scratchAutoInc),
      .scratchWrData_i  (scratchWrData),
      .scratchWrEn_i    (scratchWrEn),
      .scratchRdEn_i    (scratchRdEn),
      .scratchRdData_o  (scratchRdData),
      .scratchRdValid_o (scratchRdValid),
      .initDone_o       (initDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         a;
      logic [63:0] d;
      logic [7:0]  be;
   } wr_t;

   logic [63:0] mem_m [DEPTH];
   wr_t         pendq[$];
   int          ptr_m;
   bit          exp_rv;
   logic [7:0]  exp_rd;
   int          total = 0;
   int          bad = 0;

   function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] be);
      for (int b = 0; b < 8; b++) if (be[b]) o[b*8 +: 8] = d[b*8 +: 8];
      return o;
   endfunction

   task automatic idle();
      we = 0; wrAddr = '0; wrData = '0; wrByteEn = '0;
      scratchAddr = '0; scratchAddrLd = 0; scratchAutoInc = 0;
      scratchWrData = '0; scratchWrEn = 0; scratchRdEn = 0;
   endtask

   // advance the model by one clock using the currently driven inputs, then clock the DUT
   task automatic cycle();
      int         eff;
      bit         acc;
      logic [7:0] rb;
      wr_t        p;
      eff = scratchAddrLd ? int'(scratchAddr) : ptr_m;
      acc = we && pendq.size() == 0;
      rb  = mem_m[eff / 8][(eff % 8) * 8 +: 8];
      exp_rv = 0;
      if (scratchWrEn) begin
         mem_m[eff / 8][(eff % 8) * 8 +: 8] = scratchWrData;
         if (acc) pendq.push_back('{int'(wrAddr), wrData, wrByteEn});
      end else begin
         if (scratchRdEn) begin
            exp_rv = 1;
            exp_rd = rb;
         end
         if (pendq.size() != 0) begin
            p = pendq.pop_front();
            mem_m[p.a] = merge(mem_m[p.a], p.d, p.be);
         end else if (acc) mem_m[wrAddr] = merge(mem_m[wrAddr], wrData, wrByteEn);
      end
      if (scratchWrEn || scratchRdEn) ptr_m = scratchAutoInc ? (eff + 1) % (DEPTH * BYTES) : eff;
      else if (scratchAddrLd) ptr_m = int'(scratchAddr);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 0; #1;
      total++;
      if ({rdData, wrReady, scratchRdData, scratchRdValid, initDone} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: rdData=%h wrReady=%b srd=%h srv=%b initDone=%b expected all 0",
                  rdData, wrReady, scratchRdData, scratchRdValid, initDone);
      end
      idle();
      @(posedge clk); @(posedge clk); #1;
      reset = 1;
      pendq.delete(); ptr_m = 0; exp_rv = 0; exp_rd = '0;
   endtask

   task automatic sweep_check();
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (initDone !== 0 || rdData !== '0 || wrReady !== 0 || scratchRdValid !== 0) begin
            bad++;
            $display("FAIL sweep cycle %0d: initDone=%b wrReady=%b srv=%b rdData=%h expected 0 0 0 0",
                     i + 1, initDone, wrReady, scratchRdValid, rdData);
         end
         @(posedge clk); #1;
      end
      total++;
      if (initDone !== 1) begin
         bad++;
         $display("FAIL sweep_done: initDone=%b expected 1 on cycle %0d", initDone, DEPTH + 1);
      end
      for (int e = 0; e < DEPTH; e++) mem_m[e] = '0;
   endtask

   task automatic test_reset();
      do_reset();
      we = 1; wrAddr = 8'd9; wrData = '1; wrByteEn = '1;
      scratchRdEn = 1; scratchWrEn = 1; scratchAddrLd = 1; scratchAddr = 11'h155;
      scratchAutoInc = 1; scratchWrData = 8'h99; rdAddr = {8'd42, 8'd9};
      sweep_check();
      idle(); #1;
      total++;
      if (rdData !== '0) begin
         bad++;
         $display("FAIL clear_ignores_writes: rdData=%h expected 0", rdData);
      end
      we = 1; wrAddr = 0; wrData = 64'hC3; wrByteEn = 8'h01;
      cycle();
      we = 0; scratchRdEn = 1;
      cycle();
      scratchRdEn = 0;
      total++;
      if (scratchRdValid !== 1 || scratchRdData !== 8'hC3) begin
         bad++;
         $display("FAIL ptr_after_clear: srv=%b srd=%h expected 1 c3", scratchRdValid, scratchRdData);
      end
   endtask

   task automatic test_core_write();
      we = 1; wrAddr = 8'd5; wrData = 64'h1122334455667788; wrByteEn = 8'h0F; #1;
      total++;
      if (wrReady !== 1) begin
         bad++;
         $display("FAIL core_ready: wrReady=%b expected 1", wrReady);
      end
      cycle();
      we = 0; rdAddr = {8'd5, 8'd5}; #1;
      total++;
      if (rdData[63:0] !== 64'h0000000055667788 || rdData[127:64] !== 64'h0000000055667788) begin
         bad++;
         $display("FAIL core_bytemask: p0=%h p1=%h expected 0000000055667788", rdData[63:0], rdData[127:64]);
      end
      for (int i = 0; i < 6; i++) begin
         we = 1; wrAddr = 8'($urandom_range(16, 40)); wrData = {$urandom, $urandom}; wrByteEn = 8'($urandom);
         rdAddr = {wrAddr, wrAddr};
         cycle();
         we = 0; #1;
         total++;
         if (rdData[63:0] !== mem_m[wrAddr] || rdData[127:64] !== mem_m[wrAddr]) begin
            bad++;
            $display("FAIL core_rand %0d: p0=%h p1=%h expected %h", i, rdData[63:0], rdData[127:64], mem_m[wrAddr]);
         end
      end
   endtask

   task automatic test_collision();
      scratchAddrLd = 1; scratchAddr = 11'h02A; scratchWrEn = 1; scratchWrData = 8'hAB;
      we = 1; wrAddr = 8'd3; wrData = '1; wrByteEn = '1; rdAddr = {8'd3, 8'd5}; #1;
      total++;
      if (wrReady !== 1) begin
         bad++;
         $display("FAIL coll_ready_before: wrReady=%b expected 1", wrReady);
      end
      cycle();
      idle(); #1;
      total++;
      if (wrReady !== 0 || rdData[23:16] !== 8'hAB || rdData[127:64] === '1) begin
         bad++;
         $display("FAIL coll_pending: wrReady=%b lane2=%h e3=%h expected 0 ab not-ones",
                  wrReady, rdData[23:16], rdData[127:64]);
      end
      cycle();
      total++;
      if (wrReady !== 1 || rdData[127:64] !== '1) begin
         bad++;
         $display("FAIL coll_commit: wrReady=%b e3=%h expected 1 ffffffffffffffff", wrReady, rdData[127:64]);
      end
   endtask

   task automatic test_autoinc();
      logic [7:0] want [4];
      want[0] = 8'hA6; want[1] = 8'hA7; want[2] = 8'h01; want[3] = 8'h02;
      we = 1; wrByteEn = '1; wrAddr = 8'd255; wrData = 64'hA7A6A5A4A3A2A1A0;
      cycle();
      wrAddr = 8'd0; wrData = 64'h0807060504030201;
      cycle();
      idle(); scratchAddrLd = 1; scratchAddr = 11'h7FE; scratchAutoInc = 1;
      cycle();
      scratchAddrLd = 0; scratchRdEn = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         total++;
         if (scratchRdValid !== 1 || scratchRdData !== want[i]) begin
            bad++;
            $display("FAIL autoinc_read %0d: srv=%b srd=%h expected 1 %h", i, scratchRdValid, scratchRdData, want[i]);
         end
      end
      scratchRdEn = 0;
      cycle();
      total++;
      if (scratchRdValid !== 0 || scratchRdData !== 8'h01) begin
         bad++;
         $display("FAIL autoinc_hold: srv=%b srd=%h expected 0 01", scratchRdValid, scratchRdData);
      end
      scratchRdEn = 1;
      cycle();
      scratchRdEn = 0;
      total++;
      if (scratchRdValid !== 1 || scratchRdData !== want[3]) begin
         bad++;
         $display("FAIL autoinc_wrap_ptr: srv=%b srd=%h expected 1 %h", scratchRdValid, scratchRdData, want[3]);
      end
      idle();
   endtask

   task automatic test_wr_rd();
      scratchAddrLd = 1; scratchAddr = 11'h013; scratchWrEn = 1; scratchRdEn = 1; scratchWrData = 8'h5C;
      rdAddr = {8'd2, 8'd2};
      cycle();
      idle(); #1;
      total++;
      if (scratchRdValid !== 0 || rdData[31:24] !== 8'h5C || rdData[127:64] !== mem_m[2]) begin
         bad++;
         $display("FAIL wr_wins: srv=%b lane3=%h word=%h expected 0 5c %h",
                  scratchRdValid, rdData[31:24], rdData[127:64], mem_m[2]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         we = 1'($urandom_range(0, 1)); wrAddr = 8'($urandom_range(0, 15));
         wrData = {$urandom, $urandom}; wrByteEn = 8'($urandom);
         scratchWrEn = $urandom_range(0, 9) < 3; scratchRdEn = 1'($urandom_range(0, 1));
         scratchAddrLd = $urandom_range(0, 9) < 2; scratchAddr = 11'($urandom_range(0, 127));
         scratchAutoInc = $urandom_range(0, 3) != 0; scratchWrData = 8'($urandom);
         rdAddr = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
         #1;
         total++;
         if (wrReady !== (pendq.size() == 0)) begin
            bad++;
            $display("FAIL rand_ready %0d: wrReady=%b expected %b", i, wrReady, pendq.size() == 0);
         end
         for (int p = 0; p < NUM_RD; p++) begin
            total++;
            if (rdData[p*WIDTH +: WIDTH] !== mem_m[rdAddr[p*INDEX +: INDEX]]) begin
               bad++;
               $display("FAIL rand_rd %0d port %0d: got %h expected %h", i, p,
                        rdData[p*WIDTH +: WIDTH], mem_m[rdAddr[p*INDEX +: INDEX]]);
            end
         end
         cycle();
         total++;
         if (scratchRdValid !== exp_rv || scratchRdData !== exp_rd) begin
            bad++;
            $display("FAIL rand_scratch %0d: srv=%b srd=%h expected %b %h", i, scratchRdValid, scratchRdData, exp_rv, exp_rd);
         end
      end
      idle();
      cycle();
   endtask

   task automatic test_reset_mid();
      scratchWrEn = 1; scratchAddrLd = 1; scratchAddr = 11'h040; scratchWrData = 8'h11;
      we = 1; wrAddr = 8'd7; wrData = '1; wrByteEn = '1;
      cycle();
      we = 0; scratchAddrLd = 0; #1;
      total++;
      if (wrReady !== 0) begin
         bad++;
         $display("FAIL mid_pending: wrReady=%b expected 0", wrReady);
      end
      do_reset();
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
      end
      reset = 0; #1;
      total++;
      if (initDone !== 0 || rdData !== '0 || wrReady !== 0) begin
         bad++;
         $display("FAIL mid_reset: initDone=%b wrReady=%b rdData=%h expected 0 0 0", initDone, wrReady, rdData);
      end
      @(posedge clk); #1;
      reset = 1;
      rdAddr = {8'd7, 8'd7};
      sweep_check();
      for (int i = 0; i < 3; i++) cycle();
      total++;
      if (rdData[63:0] !== '0 || wrReady !== 1) begin
         bad++;
         $display("FAIL mid_pending_lost: e7=%h wrReady=%b expected 0 1", rdData[63:0], wrReady);
      end
   endtask

   initial begin
      idle();
      rdAddr = '0;
      #2;
      test_reset();
      test_core_write();
      test_collision();
      test_autoinc();
      test_wr_rd();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
